konark_boot_sequencer: RTL
==========================

# konark_boot_sequencer

Synthesizable multi-cluster bring-up sequencer that replaces the fixed, single-cluster boot flow used in simulation: wait for reset, hold off a programmable delay, write the entry point into each cluster's scratch register, then raise the software interrupt of every core. It sits in the Konark SoC control domain. It drives a simple valid/ready write port, bridged to the narrow AXI crossbar, and the per-core `msip` lines of up to `NrClusters` clusters.

## Interface
- `NrClusters`, 4: number of clusters sequenced.
- `NrCores`, 9: cores per cluster; the width of each cluster's `msip` slice.
- `AddrWidth`, 48: write address width.
- `DataWidth`, 64: write data width; the entry point is zero-extended into it.
- `ClusterStride`, 'h4_0000: address distance between consecutive cluster bases.
- `ScratchOffset`, 'h3_0180: scratch (entry-point) register offset inside a cluster.
- `StartupDelay`, 300: number of cycles held in WAIT; 0 skips WAIT.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: level request to run the sequence.
- `cluster_mask_i`, in, NrClusters: clusters to boot, sampled with `start_i`.
- `cluster_base_addr_i`, in, AddrWidth: base address of cluster 0, sampled with `start_i`.
- `entry_point_i`, in, DataWidth: boot address, sampled with `start_i`.
- `irq_clear_i`, in, 1: clears all `msip_o` bits.
- `wr_valid_o`, out, 1: write request valid.
- `wr_ready_i`, in, 1: write request accepted.
- `wr_addr_o`, out, AddrWidth: write address.
- `wr_data_o`, out, DataWidth: write data.
- `wr_rsp_valid_i`, in, 1: write response valid. The sequencer is always ready for it.
- `wr_rsp_err_i`, in, 1: write response error, qualified by `wr_rsp_valid_i`.
- `msip_o`, out, NrClusters*NrCores: software interrupt; bit `c*NrCores+k` drives core k of cluster c.
- `busy_o`, out, 1: state is not IDLE and not DONE.
- `done_o`, out, 1: state is DONE.
- `err_o`, out, 1: sticky; at least one write response returned an error since the last start.

## Operation
- States: IDLE, WAIT, WRITE, RESP, DONE. All outputs are registered or decoded directly from registered state.
- IDLE:
  - When `start_i`=1, latch mask, base and entry point.
  - Clear the per-cluster ok mask, `err_o` and the delay counter.
  - Go to WAIT, or to WRITE if `StartupDelay`=0.
  - If the mask is all zero, go directly to DONE.
- WAIT: counter increments each cycle. After exactly `StartupDelay` cycles in WAIT, go to WRITE with cluster index = lowest set mask bit.
- WRITE:
  - `wr_valid_o`=1.
  - `wr_addr_o` = base + idx*ClusterStride + ScratchOffset, computed modulo 2^AddrWidth.
  - `wr_data_o` = latched entry point.
  - Address and data are stable while valid is high. Valid never drops before ready.
  - On `wr_valid_o & wr_ready_i`, go to RESP.
- RESP:
  - On `wr_rsp_valid_i` without error, set ok[idx].
  - On error, set `err_o` and leave ok[idx] clear.
  - Then go to WRITE for the next higher set mask bit, or to DONE if none remain.
  - Responses arriving outside RESP are ignored.
- Entering DONE: `msip_o` bits for all cores of every cluster with ok[c]=1 are set in the same cycle, as a broadcast. Clusters with errors or masked-off clusters get no interrupt.
- DONE: returns to IDLE when `start_i`=0. A new sequence therefore needs `start_i` to deassert and reassert. `msip_o` stays set across this.
- `irq_clear_i`=1 clears all `msip_o` bits in any state. In the cycle DONE is entered, the set takes precedence over the clear.
- Asynchronous reset at any point forces IDLE immediately. An outstanding write is abandoned, and its late response is ignored because the state is IDLE.

## Timing
- Reset values:
  - `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0.
  - `msip_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0.
  - State IDLE, counter 0.
- `start_i` sampled high at edge k: WAIT during cycles k+1 … k+StartupDelay; `wr_valid_o` first high in cycle k+1+StartupDelay.
- Request accepted at edge j: RESP from cycle j+1. A response at edge r gives either the next `wr_valid_o` in cycle r+1, or `done_o` and `msip_o` in cycle r+1.
- Only one write is outstanding at a time. Per-cluster cost is at least 2 cycles with zero-wait ready and response.
- `wr_ready_i` held low stalls WRITE indefinitely. No timeout.

## Test plan
- Single cluster: NrClusters=1, StartupDelay=4, mask=1, base=0x1000_0000, entry=0x8000_0000, ready and response at zero wait, start at edge 0.
  - Expected: `wr_valid_o` in cycle 5 with addr 0x1003_0180 and data 0x8000_0000.
  - Expected: `done_o`=1 and all 9 `msip_o` bits =1 in cycle 7.
- Sparse mask: mask=4'b1010.
  - Expected: exactly two writes, to base+0x4_0000+0x3_0180 and then base+0xC_0000+0x3_0180.
  - Expected: `msip_o` set only for clusters 1 and 3, both in the same cycle.
- Error path: mask=4'b0011, cluster 0 response error.
  - Expected: `err_o`=1; cluster 1 still written; only cluster 1 `msip_o` set.
- Backpressure and zero edge cases:
  - `wr_ready_i` low for 10 cycles: `wr_valid_o`, addr and data are held constant throughout.
  - StartupDelay=0: first valid in cycle k+1.
  - mask=0: `done_o` in cycle k+1 with no write and `msip_o`=0.
- Clear and restart:
  - `irq_clear_i` pulsed in DONE clears `msip_o` next cycle.
  - `irq_clear_i` asserted on the DONE-entry cycle: `msip_o` still set.
  - `start_i` held high: no rerun. Drop it, then raise it: the second sequence runs.
- Reset mid-operation: assert `rst_ni` low while in RESP.
  - Expected: all outputs return to reset values immediately.
  - Expected: a response arriving after release is ignored, and `err_o` stays 0.

Source files
------------

// File: rtl/konark_boot_sequencer.sv
// Multi-cluster boot sequencer: waits a programmable delay, writes the entry point into each selected cluster's scratch register, then raises msip for every cluster whose write succeeded.
// Latency: first write request StartupDelay+1 cycles after start; >= 2 cycles per cluster; DONE/msip 1 cycle after the last response.
// Backpressure: one write outstanding; WRITE holds addr/data/valid until wr_ready_i, with no timeout. Responses are always accepted.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   start_i, cluster_mask_i,         level start request; mask/base/entry are latched when
//   cluster_base_addr_i, entry_point_i  start_i is seen in IDLE
//   irq_clear_i                      clears every msip_o bit (a same-cycle DONE-entry set wins)
//   wr_valid_o/wr_ready_i/wr_addr_o/wr_data_o   write request channel
//   wr_rsp_valid_i/wr_rsp_err_i      write response (always ready)
//   msip_o                           bit c*NrCores+k drives core k of cluster c
//   busy_o, done_o, err_o            status; err_o is sticky until the next start

module konark_boot_sequencer #(
  parameter int                   NrClusters    = 4,
  parameter int                   NrCores       = 9,
  parameter int                   AddrWidth     = 48,
  parameter int                   DataWidth     = 64,
  parameter logic [AddrWidth-1:0] ClusterStride = 'h4_0000,
  parameter logic [AddrWidth-1:0] ScratchOffset = 'h3_0180,
  parameter int                   StartupDelay  = 300
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [NrClusters-1:0]         cluster_mask_i,
  input  logic [AddrWidth-1:0]          cluster_base_addr_i,
  input  logic [DataWidth-1:0]          entry_point_i,
  input  logic                          irq_clear_i,
  output logic                          wr_valid_o,
  input  logic                          wr_ready_i,
  output logic [AddrWidth-1:0]          wr_addr_o,
  output logic [DataWidth-1:0]          wr_data_o,
  input  logic                          wr_rsp_valid_i,
  input  logic                          wr_rsp_err_i,
  output logic [NrClusters*NrCores-1:0] msip_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int IdxW = (NrClusters > 1) ? $clog2(NrClusters) : 1;
  // The counter only has to reach StartupDelay-1.
  localparam int CntW = (StartupDelay > 1) ? $clog2(StartupDelay) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_RESP,
    S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NrClusters-1:0]         mask_q, mask_d;
  logic [AddrWidth-1:0]          base_q, base_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic [NrClusters-1:0]         ok_q, ok_d;
  logic                          err_q, err_d;
  logic [AddrWidth-1:0]          addr_q, addr_d;
  logic [DataWidth-1:0]          data_q, data_d;
  logic [NrClusters*NrCores-1:0] msip_q, msip_d;

  // Lowest set mask bit at or above 'from'; MSB of the result flags "found".
  function automatic logic [IdxW:0] pick_from(input logic [NrClusters-1:0] m, input int from);
    logic [IdxW:0] r;
    r = '0;
    for (int i = NrClusters - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, IdxW'(i)};
    end
    return r;
  endfunction

  logic [NrClusters-1:0]         pick_mask;
  logic [AddrWidth-1:0]          pick_base;
  int                            pick_lo;
  logic [IdxW:0]                 pick;
  logic [AddrWidth-1:0]          pick_addr;
  logic                          enter_done;
  logic [NrClusters*NrCores-1:0] msip_set;

  // Next-cluster selection. In IDLE the choice is made on the live inputs
  // because a zero StartupDelay goes straight to WRITE on the start edge.
  always_comb begin
    pick_mask = mask_q;
    pick_base = base_q;
    pick_lo   = 0;
    if (state_q == S_IDLE) begin
      pick_mask = cluster_mask_i;
      pick_base = cluster_base_addr_i;
    end
    if (state_q == S_RESP) pick_lo = int'(idx_q) + 1;
    pick      = pick_from(pick_mask, pick_lo);
    // Address arithmetic wraps at AddrWidth bits.
    pick_addr = pick_base + AddrWidth'(pick[IdxW-1:0]) * ClusterStride + ScratchOffset;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    base_d     = base_q;
    idx_d      = idx_q;
    ok_d       = ok_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    enter_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d = cluster_mask_i;
          base_d = cluster_base_addr_i;
          data_d = entry_point_i;
          ok_d   = '0;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (cluster_mask_i == '0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else if (StartupDelay == 0) begin
            state_d = S_WRITE;
            idx_d   = pick[IdxW-1:0];
            addr_d  = pick_addr;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        if (32'(cnt_q) == StartupDelay - 1) begin
          state_d = S_WRITE;
          idx_d   = pick[IdxW-1:0];
          addr_d  = pick_addr;
        end
      end

      S_WRITE: begin
        if (wr_ready_i) state_d = S_RESP;
      end

      S_RESP: begin
        if (wr_rsp_valid_i) begin
          if (wr_rsp_err_i) err_d = 1'b1;
          else              ok_d[idx_q] = 1'b1;
          if (pick[IdxW]) begin
            state_d = S_WRITE;
            idx_d   = pick[IdxW-1:0];
            addr_d  = pick_addr;
          end else begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Start is level-sensitive: it must drop before another run.
        if (!start_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Broadcast set on DONE entry; it is OR-ed after the clear so it wins.
  always_comb begin
    msip_set = '0;
    for (int c = 0; c < NrClusters; c++) begin
      msip_set[c*NrCores +: NrCores] = {NrCores{ok_d[c]}};
    end
    msip_d = irq_clear_i ? '0 : msip_q;
    if (enter_done) msip_d = msip_d | msip_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      ok_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      msip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      msip_q  <= msip_d;
    end
  end

  assign wr_valid_o = (state_q == S_WRITE);
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign msip_o     = msip_q;
  assign busy_o     = (state_q == S_WAIT) || (state_q == S_WRITE) || (state_q == S_RESP);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;

endmodule
